// File: rtl/square_rem.sv
// Rebuilds V = R*R + M from an integer square root R and its remainder M.
// The square is formed by MSB-first shift-and-add, one root bit per cycle.
module square_rem (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_root,
   input  logic [4:0] in_rem,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_value,
   output logic       out_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] acc;
   logic [1:0] cnt;
   logic [3:0] r_q;
   logic [4:0] m_q;
   logic       err_q;
   logic       accept;

   assign accept = in_valid && (state_q == IDLE);

   // NOTE: state is written with non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid)      state_d = MUL;
         MUL:  if (cnt == 2'd0)   state_d = ADD;
         ADD:                     state_d = DONE;
         DONE: if (out_ready)     state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= 8'd0;
         cnt   <= 2'd0;
         r_q   <= 4'd0;
         m_q   <= 5'd0;
         err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  r_q   <= in_root;
                  m_q   <= in_rem;
                  // A legal remainder never exceeds 2R, else (R+1)^2 would fit.
                  err_q <= (in_rem > {in_root, 1'b0});
                  acc   <= 8'd0;
                  cnt   <= 2'd3;
               end
            end
            MUL: begin
               acc <= (acc << 1) + (r_q[cnt] ? {4'd0, r_q} : 8'd0);
               cnt <= cnt - 2'd1;
            end
            ADD: begin
               if (!err_q) begin
                  acc <= acc + {3'd0, m_q};
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_value = acc;
   assign out_err   = err_q;

endmodule
